// File: rtl/clock_time_counter_pkg.sv
// Shared BCD constants, the packed time-of-day type and BCD digit helpers.
// Combinational definitions only; no latency, no backpressure.
package clock_time_counter_pkg;

    localparam logic [7:0] BCD_ZERO      = 8'h00;
    localparam logic [7:0] SEC_MAX       = 8'h59;
    localparam logic [7:0] MIN_MAX       = 8'h59;
    localparam logic [7:0] HOUR_MAX      = 8'h23;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'h9;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } bcd_time_t;

    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= BCD_DIGIT_MAX) && (v[3:0] <= BCD_DIGIT_MAX);
    endfunction

    // Successor of a BCD pair modulo (max + 1); max itself must be valid BCD.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return BCD_ZERO;
        else if (v[3:0] == BCD_DIGIT_MAX)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/clock_time_counter_bcd_mod_counter.sv
// Two-digit BCD counter modulo MAX+1 with synchronous load and wrap carry.
// Latency 1 cycle from en/load to q; carry is combinational (en & q==MAX).
// No backpressure: en and load are single-cycle strobes, load wins over en.
module bcd_mod_counter
    import clock_time_counter_pkg::*;
#(
    parameter logic [7:0] MAX = SEC_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic       carry
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= BCD_ZERO;
        else if (load)
            q <= load_val;
        else if (en)
            q <= bcd_next(q, MAX);
    end

    assign carry = en & (q == MAX);

endmodule

// File: rtl/clock_time_counter.sv
// BCD hour/minute/second time-of-day counter with adjust and validated load.
// Latency 1 cycle from Tick/Load to Hour/Minute/Second, Day_Carry, Load_Err.
// No backpressure: Tick and Load are single-cycle strobes, always consumed.
module clock_time_counter #(
    parameter logic [7:0] HOUR_MAX = clock_time_counter_pkg::HOUR_MAX,
    parameter logic [7:0] SEC_MAX  = clock_time_counter_pkg::SEC_MAX
) (
    input  logic       _1KHz,
    input  logic       nCR,
    input  logic       Tick,
    input  logic       Adj_Min,
    input  logic       Adj_Hour,
    input  logic       Load,
    input  logic [7:0] Set_Hour,
    input  logic [7:0] Set_Min,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic       Day_Carry,
    output logic       Load_Err
);

    import clock_time_counter_pkg::BCD_ZERO;
    import clock_time_counter_pkg::bcd_time_t;
    import clock_time_counter_pkg::bcd_digits_ok;

    bcd_time_t now;
    logic      set_ok;
    logic      load_acc;
    logic      load_rej;
    logic      tick_run;
    logic      sec_carry;
    logic      min_en;
    logic      min_carry;
    logic      hour_en;
    logic      hour_carry;
    logic      day_wrap;

    always_comb begin
        set_ok = bcd_digits_ok(Set_Hour) && bcd_digits_ok(Set_Min) &&
                 (Set_Min <= SEC_MAX) && (Set_Hour <= HOUR_MAX);
    end

    assign load_acc = Load & set_ok;
    assign load_rej = Load & ~set_ok;
    // An accepted load swallows the coincident tick; a rejected one does not.
    assign tick_run = Tick & ~load_acc;

    // Adjust takes the tick directly and cuts the ripple carry from below.
    assign min_en   = Adj_Min  ? tick_run : sec_carry;
    assign hour_en  = Adj_Hour ? tick_run : (min_carry & ~Adj_Min);
    assign day_wrap = hour_carry & ~Adj_Hour;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (_1KHz),
        .rst_n    (nCR),
        .en       (tick_run),
        .load     (load_acc),
        .load_val (BCD_ZERO),
        .q        (now.second),
        .carry    (sec_carry)
    );

    bcd_mod_counter #(.MAX(SEC_MAX)) u_min (
        .clk      (_1KHz),
        .rst_n    (nCR),
        .en       (min_en),
        .load     (load_acc),
        .load_val (Set_Min),
        .q        (now.minute),
        .carry    (min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk      (_1KHz),
        .rst_n    (nCR),
        .en       (hour_en),
        .load     (load_acc),
        .load_val (Set_Hour),
        .q        (now.hour),
        .carry    (hour_carry)
    );

    // A rejected load at midnight still wraps the time, but only the error
    // is flagged so the two pulses stay mutually exclusive.
    always_ff @(posedge _1KHz) begin
        if (!nCR) begin
            Day_Carry <= 1'b0;
            Load_Err  <= 1'b0;
        end else begin
            Day_Carry <= day_wrap & ~load_rej;
            Load_Err  <= load_rej;
        end
    end

    assign Hour   = now.hour;
    assign Minute = now.minute;
    assign Second = now.second;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed self-checking bench for clock_time_counter.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_clock_time_counter;

    logic       clk = 1'b0;
    logic       nCR = 1'b0;
    logic       Tick = 1'b0;
    logic       Adj_Min = 1'b0;
    logic       Adj_Hour = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] Set_Hour = 8'h00;
    logic [7:0] Set_Min = 8'h00;
    logic [7:0] Hour;
    logic [7:0] Minute;
    logic [7:0] Second;
    logic       Day_Carry;
    logic       Load_Err;

    int n_checks = 0;
    int n_fail   = 0;

    clock_time_counter dut (
        ._1KHz     (clk),
        .nCR       (nCR),
        .Tick      (Tick),
        .Adj_Min   (Adj_Min),
        .Adj_Hour  (Adj_Hour),
        .Load      (Load),
        .Set_Hour  (Set_Hour),
        .Set_Min   (Set_Min),
        .Hour      (Hour),
        .Minute    (Minute),
        .Second    (Second),
        .Day_Carry (Day_Carry),
        .Load_Err  (Load_Err)
    );

    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            Tick = 1'b1;
            @(negedge clk);
            Tick = 1'b0;
            @(negedge clk);
        end
    endtask

    // Leaves the cycle right after the load edge visible for checking.
    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic t);
        Set_Hour = h;
        Set_Min  = m;
        Load     = 1'b1;
        Tick     = t;
        @(negedge clk);
        Load = 1'b0;
        Tick = 1'b0;
    endtask

    task automatic test_reset();
        nCR = 1'b0; Tick = 1'b1; Load = 1'b1; Set_Hour = 8'h12; Set_Min = 8'h34;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h000000) begin
            n_fail++; $display("FAIL reset_time: got %h expected 000000", {Hour, Minute, Second});
        end
        n_checks++;
        if (Day_Carry !== 1'b0) begin
            n_fail++; $display("FAIL reset_day_carry: got %b expected 0", Day_Carry);
        end
        n_checks++;
        if (Load_Err !== 1'b0) begin
            n_fail++; $display("FAIL reset_load_err: got %b expected 0", Load_Err);
        end
        Tick = 1'b0; Load = 1'b0; nCR = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_count();
        do_load(8'h12, 8'h34, 1'b1);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h123400) begin
            n_fail++; $display("FAIL load_tick_discard: got %h expected 123400", {Hour, Minute, Second});
        end
        n_checks++;
        if (Load_Err !== 1'b0) begin
            n_fail++; $display("FAIL load_ok_err: got %b expected 0", Load_Err);
        end
        tick_n(5);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h123405) begin
            n_fail++; $display("FAIL count_5: got %h expected 123405", {Hour, Minute, Second});
        end
    endtask

    task automatic test_day_wrap();
        do_load(8'h23, 8'h59, 1'b0);
        n_checks++;
        if (Load_Err !== 1'b0) begin
            n_fail++; $display("FAIL load_max_err: got %b expected 0", Load_Err);
        end
        tick_n(59);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h235959) begin
            n_fail++; $display("FAIL pre_wrap: got %h expected 235959", {Hour, Minute, Second});
        end
        Tick = 1'b1;
        @(negedge clk);
        Tick = 1'b0;
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h000000) begin
            n_fail++; $display("FAIL day_wrap_time: got %h expected 000000", {Hour, Minute, Second});
        end
        n_checks++;
        if (Day_Carry !== 1'b1) begin
            n_fail++; $display("FAIL day_carry_pulse: got %b expected 1", Day_Carry);
        end
        @(negedge clk);
        n_checks++;
        if (Day_Carry !== 1'b0) begin
            n_fail++; $display("FAIL day_carry_width: got %b expected 0", Day_Carry);
        end
    endtask

    task automatic test_adjust();
        do_load(8'h10, 8'h59, 1'b0);
        tick_n(59);
        Adj_Min = 1'b1; Tick = 1'b1;
        @(negedge clk);
        Adj_Min = 1'b0; Tick = 1'b0;
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h100000) begin
            n_fail++; $display("FAIL adj_min_wrap: got %h expected 100000", {Hour, Minute, Second});
        end
        do_load(8'h23, 8'h15, 1'b0);
        Adj_Hour = 1'b1; Tick = 1'b1;
        @(negedge clk);
        Adj_Hour = 1'b0; Tick = 1'b0;
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h001501) begin
            n_fail++; $display("FAIL adj_hour_wrap: got %h expected 001501", {Hour, Minute, Second});
        end
        n_checks++;
        if (Day_Carry !== 1'b0) begin
            n_fail++; $display("FAIL adj_hour_day_carry: got %b expected 0", Day_Carry);
        end
        do_load(8'h23, 8'h59, 1'b0);
        tick_n(59);
        Adj_Hour = 1'b1; Tick = 1'b1;
        @(negedge clk);
        Adj_Hour = 1'b0; Tick = 1'b0;
        n_checks++;
        if ({Hour, Minute, Second, Day_Carry} !== {24'h000000, 1'b0}) begin
            n_fail++; $display("FAIL adj_hour_midnight: got %h/%b expected 000000/0", {Hour, Minute, Second}, Day_Carry);
        end
        do_load(8'h05, 8'h20, 1'b0);
        Adj_Hour = 1'b1; Adj_Min = 1'b1; Tick = 1'b1;
        @(negedge clk);
        Adj_Hour = 1'b0; Adj_Min = 1'b0; Tick = 1'b0;
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h062101) begin
            n_fail++; $display("FAIL adj_both: got %h expected 062101", {Hour, Minute, Second});
        end
    endtask

    task automatic test_load_reject();
        do_load(8'h12, 8'h34, 1'b0);
        do_load(8'h12, 8'h60, 1'b0);
        n_checks++;
        if ({Hour, Minute, Second, Load_Err} !== {24'h123400, 1'b1}) begin
            n_fail++; $display("FAIL rej_min60: got %h/%b expected 123400/1", {Hour, Minute, Second}, Load_Err);
        end
        @(negedge clk);
        n_checks++;
        if (Load_Err !== 1'b0) begin
            n_fail++; $display("FAIL rej_err_width: got %b expected 0", Load_Err);
        end
        do_load(8'h1A, 8'h00, 1'b1);
        n_checks++;
        if ({Hour, Minute, Second, Load_Err} !== {24'h123401, 1'b1}) begin
            n_fail++; $display("FAIL rej_hour1A: got %h/%b expected 123401/1", {Hour, Minute, Second}, Load_Err);
        end
        do_load(8'h24, 8'h00, 1'b1);
        n_checks++;
        if ({Hour, Minute, Second, Load_Err} !== {24'h123402, 1'b1}) begin
            n_fail++; $display("FAIL rej_hour24: got %h/%b expected 123402/1", {Hour, Minute, Second}, Load_Err);
        end
        @(negedge clk);
    endtask

    task automatic test_bcd_rollover();
        do_load(8'h09, 8'h09, 1'b0);
        tick_n(51);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h090951) begin
            n_fail++; $display("FAIL bcd_sec_roll: got %h expected 090951", {Hour, Minute, Second});
        end
        do_load(8'h09, 8'h59, 1'b0);
        tick_n(60);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h100000) begin
            n_fail++; $display("FAIL bcd_hour_09_10: got %h expected 100000", {Hour, Minute, Second});
        end
        do_load(8'h19, 8'h59, 1'b0);
        tick_n(60);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h200000) begin
            n_fail++; $display("FAIL bcd_hour_19_20: got %h expected 200000", {Hour, Minute, Second});
        end
    endtask

    task automatic test_back_to_back();
        do_load(8'h01, 8'h02, 1'b0);
        do_load(8'h03, 8'h04, 1'b1);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h030400) begin
            n_fail++; $display("FAIL b2b_load: got %h expected 030400", {Hour, Minute, Second});
        end
    endtask

    task automatic test_reset_mid();
        do_load(8'h12, 8'h34, 1'b0);
        nCR = 1'b0; Adj_Min = 1'b1; Tick = 1'b1; Load = 1'b1; Set_Hour = 8'h01; Set_Min = 8'h01;
        @(negedge clk);
        nCR = 1'b1; Adj_Min = 1'b0; Tick = 1'b0; Load = 1'b0;
        n_checks++;
        if ({Hour, Minute, Second, Day_Carry, Load_Err} !== {24'h000000, 2'b00}) begin
            n_fail++; $display("FAIL reset_mid: got %h/%b%b expected 000000/00", {Hour, Minute, Second}, Day_Carry, Load_Err);
        end
        tick_n(1);
        n_checks++;
        if ({Hour, Minute, Second} !== 24'h000001) begin
            n_fail++; $display("FAIL after_reset_tick: got %h expected 000001", {Hour, Minute, Second});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_count();
        test_day_wrap();
        test_adjust();
        test_load_reject();
        test_bcd_rollover();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
